// File: rtl/cnnip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cnnip_mem_arbiter
// Purpose  : Round-robin arbiter that lets NUM_PORTS requesters share one port
//            of a native block memory. Reads are fully pipelined at the
//            memory's READ_LATENCY. A tag pipeline routes each read response
//            back to the requester that issued it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports (P = NUM_PORTS)
//   clk        in   1             single clock
//   arstz_aq   in   1             synchronous active-low reset
//   req_en     in   P             per-port access request
//   req_we     in   P             per-port write enable (1 = write)
//   req_addr   in   P*ADDR_WIDTH  per-port byte address
//   req_din    in   P*DATA_WIDTH  per-port write data
//   req_ready  out  P             combinational grant, one-hot or zero
//   rsp_valid  out  P             registered one-cycle read-data valid
//   rsp_dout   out  P*DATA_WIDTH  read data, only the addressed slice non-zero
//   busy       out  1             one or more reads in flight
//   mem_en     out  1             memory enable
//   mem_we     out  1             memory write enable
//   mem_addr   out  ADDR_WIDTH-2  memory word address
//   mem_din    out  DATA_WIDTH    memory write data
//   mem_dout   in   DATA_WIDTH    memory read data, READ_LATENCY after the read
// ============================================================================
module cnnip_mem_arbiter #(
   parameter int NUM_PORTS    = 4,
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 2
) (
   input  logic                             clk,
   input  logic                             arstz_aq,
   input  logic [NUM_PORTS-1:0]             req_en,
   input  logic [NUM_PORTS-1:0]             req_we,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_din,
   output logic [NUM_PORTS-1:0]             req_ready,
   output logic [NUM_PORTS-1:0]             rsp_valid,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_dout,
   output logic                             busy,
   output logic                             mem_en,
   output logic                             mem_we,
   output logic [ADDR_WIDTH-3:0]            mem_addr,
   output logic [DATA_WIDTH-1:0]            mem_din,
   input  logic [DATA_WIDTH-1:0]            mem_dout
);

   localparam int ID_W = $clog2(NUM_PORTS);

   logic [ID_W-1:0]         rr_ptr;
   logic                    grant_vld;
   logic [ID_W-1:0]         grant_id;
   logic [ID_W-1:0]         scan_idx;
   logic                    sel_we;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_din;
   logic                    unused_addr_lsbs;

   logic [READ_LATENCY-1:0] tag_vld;
   logic [ID_W-1:0]         tag_id [READ_LATENCY];

   // (base + k) mod NUM_PORTS without a divider; k is always < NUM_PORTS.
   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                input int              k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_PORTS) begin
         s = s - NUM_PORTS;
      end
      return ID_W'(s);
   endfunction

   // ------------------------------------------------------------------------
   // Arbitration: first requester at or after rr_ptr, scanning upward.
   // Reset suppresses the grant so nothing is accepted while it is low.
   // ------------------------------------------------------------------------
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         scan_idx = wrap_idx(rr_ptr, k);
         if (!grant_vld && req_en[scan_idx]) begin
            grant_vld = 1'b1;
            grant_id  = scan_idx;
         end
      end
      if (!arstz_aq) begin
         grant_vld = 1'b0;
      end
   end

   // Grant decode and request mux; all memory fields are zero when idle.
   always_comb begin
      req_ready = '0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_din   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_vld && (grant_id == ID_W'(i))) begin
            req_ready[i] = 1'b1;
            sel_we       = req_we[i];
            sel_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_din      = req_din[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign mem_en   = grant_vld;
   assign mem_we   = sel_we;
   assign mem_addr = sel_addr[ADDR_WIDTH-1:2];
   assign mem_din  = sel_din;

   // Byte-lane bits are meaningless to a word-addressed memory.
   assign unused_addr_lsbs = ^sel_addr[1:0];

   // ------------------------------------------------------------------------
   // Round-robin pointer: moves just past the port that was served.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!arstz_aq) begin
         rr_ptr <= '0;
      end else if (grant_vld) begin
         rr_ptr <= (grant_id == ID_W'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Tag pipeline: one stage per cycle of memory latency, never stalls, so
   // the last stage lines up exactly with the cycle mem_dout is valid.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!arstz_aq) begin
         tag_vld <= '0;
         for (int s = 0; s < READ_LATENCY; s++) begin
            tag_id[s] <= '0;
         end
      end else begin
         tag_vld[0] <= grant_vld & ~sel_we;
         tag_id[0]  <= grant_id;
         for (int s = 1; s < READ_LATENCY; s++) begin
            tag_vld[s] <= tag_vld[s-1];
            tag_id[s]  <= tag_id[s-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Response register: steer captured read data to the issuing port only.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!arstz_aq) begin
         rsp_valid <= '0;
         rsp_dout  <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (tag_vld[READ_LATENCY-1] && (tag_id[READ_LATENCY-1] == ID_W'(i))) begin
               rsp_valid[i]                        <= 1'b1;
               rsp_dout[i*DATA_WIDTH +: DATA_WIDTH] <= mem_dout;
            end else begin
               rsp_valid[i]                        <= 1'b0;
               rsp_dout[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
            end
         end
      end
   end

   assign busy = (|tag_vld) | (|rsp_valid);

endmodule
`default_nettype wire

// File: tb/tb_cnnip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnnip_mem_arbiter
// Purpose  : Self-checking bench for cnnip_mem_arbiter (4 ports). It holds a
//            behavioural memory, a queue-based reference model checked every
//            cycle, a table of arbitration vectors, directed multi-cycle
//            scenarios and a randomized traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnnip_mem_arbiter;

   parameter int RL = 2;
   localparam int P  = 4;
   localparam int AW = 12;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            arstz_aq;
   logic [P-1:0]    req_en, req_we;
   logic [P*AW-1:0] req_addr;
   logic [P*DW-1:0] req_din;
   logic [P-1:0]    req_ready, rsp_valid;
   logic [P*DW-1:0] rsp_dout;
   logic            busy, mem_en, mem_we;
   logic [AW-3:0]   mem_addr;
   logic [DW-1:0]   mem_din, mem_dout;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   cnnip_mem_arbiter #(
      .NUM_PORTS(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .arstz_aq(arstz_aq),
      .req_en(req_en), .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
      .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural block memory (read-latency RL) -------------
   logic [DW-1:0] mem_arr [0:1023];
   logic [DW-1:0] rd_pipe [RL];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem_arr[mem_addr] <= mem_din;
         else        rd_pipe[0]       <= mem_arr[mem_addr];
      end
      for (int s = 1; s < RL; s++) rd_pipe[s] <= rd_pipe[s-1];
   end
   assign mem_dout = rd_pipe[RL-1];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
   endtask

   // ---------------- reference model -----------------------------------------
   typedef struct { int due; int port; logic [DW-1:0] data; } exp_t;
   exp_t          exp_q[$];
   exp_t          keep_q[$];
   logic [DW-1:0] ref_mem [0:1023];
   int            m_ptr = 0;
   int            g, idx;
   logic [P-1:0]  m_rv, m_ready;
   logic [127:0]  m_rd;
   logic          m_busy, e_en, e_we;
   logic [AW-3:0] e_addr;
   logic [DW-1:0] e_din;

   always @(negedge clk) begin : ref_model
      m_rv = '0; m_rd = '0; m_busy = 1'b0;
      foreach (exp_q[i]) begin
         if (exp_q[i].due == cyc) begin
            m_rv[exp_q[i].port] = 1'b1;
            m_rd[exp_q[i].port*DW +: DW] = exp_q[i].data;
         end
         if (exp_q[i].due - RL <= cyc) m_busy = 1'b1;
      end
      check("model rsp_valid", 128'(rsp_valid), 128'(m_rv));
      check("model rsp_dout", rsp_dout, m_rd);
      check("model busy", 128'(busy), 128'(m_busy));
      keep_q.delete();
      foreach (exp_q[i]) if (exp_q[i].due > cyc) keep_q.push_back(exp_q[i]);
      exp_q = keep_q;

      g = -1;
      if (arstz_aq === 1'b1) begin
         for (int k = 0; k < P; k++) begin
            idx = (m_ptr + k) % P;
            if (g < 0 && req_en[idx]) g = idx;
         end
      end
      m_ready = '0; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
      if (g >= 0) begin
         m_ready[g] = 1'b1;
         e_en   = 1'b1;
         e_we   = req_we[g];
         e_addr = req_addr[g*AW+2 +: AW-2];
         e_din  = req_din[g*DW +: DW];
      end
      check("model req_ready", 128'(req_ready), 128'(m_ready));
      check("model mem_en", 128'(mem_en), 128'(e_en));
      check("model mem_we", 128'(mem_we), 128'(e_we));
      check("model mem_addr", 128'(mem_addr), 128'(e_addr));
      check("model mem_din", 128'(mem_din), 128'(e_din));

      if (arstz_aq !== 1'b1) begin
         m_ptr = 0;
         exp_q.delete();
      end else if (g >= 0) begin
         m_ptr = (g + 1) % P;
         if (e_we) ref_mem[e_addr] = e_din;
         else      exp_q.push_back('{cyc + RL + 1, g, ref_mem[e_addr]});
      end
   end

   // ---------------- stimulus helpers ----------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic en, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_en[p]          = en;
      req_we[p]          = we;
      req_addr[p*AW +: AW] = a;
      req_din[p*DW +: DW]  = d;
   endtask

   typedef struct {
      logic [P-1:0] en;
      logic [P-1:0] we;
      logic [P-1:0] ready;
      logic         men;
      logic         mwe;
   } vec_t;
   vec_t tbl [11];

   logic [P-1:0]  exp_v;
   logic [P-1:0]  gl;
   logic [DW-1:0] wd;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_arr[i] = 32'hA5A5_0000 | 32'(i);
         ref_mem[i] = 32'hA5A5_0000 | 32'(i);
      end
      // Table rows: pointer evolves 0,0,1,2,1,0,2,3,1,1,0 -> 1
      tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
      tbl[1]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0};
      tbl[2]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0};
      tbl[3]  = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0};
      tbl[4]  = '{4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b0};
      tbl[5]  = '{4'b0110, 4'b0100, 4'b0010, 1'b1, 1'b0};
      tbl[6]  = '{4'b0110, 4'b0100, 4'b0100, 1'b1, 1'b1};
      tbl[7]  = '{4'b0011, 4'b0000, 4'b0001, 1'b1, 1'b0};
      tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
      tbl[9]  = '{4'b1001, 4'b0000, 4'b1000, 1'b1, 1'b0};
      tbl[10] = '{4'b1111, 4'b0001, 4'b0001, 1'b1, 1'b1};

      // ---- reset with every port requesting: nothing may be granted ----
      arstz_aq = 1'b0;
      for (int p = 0; p < P; p++) set_port(p, 1'b1, 1'b0, AW'(12'h100 + 4*p), 32'h1111_0000 + 32'(p));
      repeat (3) tick();
      @(negedge clk);
      check("reset req_ready", 128'(req_ready), 128'(0));
      check("reset mem_en", 128'(mem_en), 128'(0));
      check("reset rsp_valid", 128'(rsp_valid), 128'(0));
      check("reset busy", 128'(busy), 128'(0));
      tick();
      arstz_aq = 1'b1;

      // ---- table-driven arbitration vectors ----
      for (int r = 0; r < 11; r++) begin
         req_en = tbl[r].en;
         req_we = tbl[r].we;
         @(negedge clk);
         check($sformatf("table%0d req_ready", r), 128'(req_ready), 128'(tbl[r].ready));
         check($sformatf("table%0d mem_en", r), 128'(mem_en), 128'(tbl[r].men));
         check($sformatf("table%0d mem_we", r), 128'(mem_we), 128'(tbl[r].mwe));
         tick();
      end
      req_en = '0; req_we = '0;
      repeat (RL + 3) tick();

      // ---- single read: port 2, byte address 0x14 (word 5) ----
      for (int k = 0; k <= RL + 2; k++) begin
         if (k == 0) set_port(2, 1'b1, 1'b0, 12'h014, '0);
         else        req_en = '0;
         @(negedge clk);
         if (k == 0) begin
            check("single mem_en", 128'(mem_en), 128'(1));
            check("single mem_addr", 128'(mem_addr), 128'(5));
            check("single req_ready", 128'(req_ready), 128'(4'b0100));
         end else begin
            check($sformatf("single busy k%0d", k), 128'(busy), 128'(k <= RL + 1));
            exp_v = (k == RL + 1) ? 4'b0100 : 4'b0000;
            check($sformatf("single rsp_valid k%0d", k), 128'(rsp_valid), 128'(exp_v));
            if (k == RL + 1)
               check("single rsp_dout", rsp_dout, {32'h0, 32'hA5A5_0005, 64'h0});
         end
         tick();
      end

      // ---- reset pulse, then all four ports read continuously ----
      arstz_aq = 1'b0;
      @(negedge clk);
      tick();
      arstz_aq = 1'b1;
      for (int k = 0; k <= RL + 9; k++) begin
         for (int p = 0; p < P; p++) set_port(p, k < 8, 1'b0, AW'(4*p), '0);
         @(negedge clk);
         if (k < 8) begin
            exp_v = 4'b0001 << (k % 4);
            check($sformatf("rr grant k%0d", k), 128'(req_ready), 128'(exp_v));
         end
         if (k >= RL + 1 && k < RL + 9) begin
            exp_v = 4'b0001 << ((k - RL - 1) % 4);
            check($sformatf("rr rsp_valid k%0d", k), 128'(rsp_valid), 128'(exp_v));
            wd = 32'hA5A5_0000 + 32'((k - RL - 1) % 4);
            check($sformatf("rr rsp_dout k%0d", k),
                  128'(rsp_dout[((k - RL - 1) % 4)*DW +: DW]), 128'(wd));
         end
         tick();
      end

      // ---- streaming: port 1 reads words 0..15 back to back ----
      for (int w = 0; w <= RL + 17; w++) begin
         req_en = '0;
         if (w < 16) set_port(1, 1'b1, 1'b0, AW'(4*w), '0);
         @(negedge clk);
         if (w < 16) check($sformatf("stream grant w%0d", w), 128'(req_ready), 128'(4'b0010));
         if (w >= RL + 1 && w < RL + 17) begin
            check($sformatf("stream rsp_valid w%0d", w), 128'(rsp_valid), 128'(4'b0010));
            wd = 32'hA5A5_0000 + 32'(w - RL - 1);
            check($sformatf("stream data w%0d", w), 128'(rsp_dout[DW +: DW]), 128'(wd));
         end else if (w > RL + 16) begin
            check($sformatf("stream tail w%0d", w), 128'(rsp_valid), 128'(0));
         end
         tick();
      end

      // ---- write 0xDEADBEEF via port 0, then port 3 reads it twice ----
      for (int k = 0; k <= RL + 6; k++) begin
         req_en = '0; req_we = '0;
         if (k == 0)          set_port(0, 1'b1, 1'b1, 12'h040, 32'hDEAD_BEEF);
         if (k == 1 || k == 4) set_port(3, 1'b1, 1'b0, 12'h040, '0);
         @(negedge clk);
         if (k == 0) begin
            check("wr mem_we", 128'(mem_we), 128'(1));
            check("wr mem_din", 128'(mem_din), 128'(32'hDEAD_BEEF));
         end
         if (k == RL + 1) check("wr no response", 128'(rsp_valid), 128'(0));
         if (k == RL + 2) check("wr read1 data", 128'(rsp_dout[3*DW +: DW]), 128'(32'hDEAD_BEEF));
         if (k == RL + 5) begin
            check("wr read2 valid", 128'(rsp_valid), 128'(4'b1000));
            check("wr read2 data", 128'(rsp_dout[3*DW +: DW]), 128'(32'hDEAD_BEEF));
         end
         tick();
      end

      // ---- reset while reads are in flight ----
      for (int c = 0; c <= RL + 6; c++) begin
         req_en = '0; req_we = '0;
         arstz_aq = (c != 2);
         if (c == 0) set_port(0, 1'b1, 1'b0, 12'h000, '0);
         if (c == 1) set_port(1, 1'b1, 1'b0, 12'h004, '0);
         if (c == 2) set_port(2, 1'b1, 1'b0, 12'h008, '0);
         if (c == 3) begin
            set_port(1, 1'b1, 1'b0, 12'h00C, '0);
            set_port(3, 1'b1, 1'b0, 12'h010, '0);
         end
         @(negedge clk);
         if (c == 0) check("mid accept", 128'(req_ready), 128'(4'b0001));
         if (c == 2) check("mid rst ready", 128'(req_ready), 128'(0));
         if (c == 3) begin
            check("mid busy after release", 128'(busy), 128'(0));
            check("mid port1 granted", 128'(req_ready), 128'(4'b0010));
         end
         if (c >= 3) begin
            exp_v = (c == 3 + RL + 1) ? 4'b0010 : 4'b0000;
            check($sformatf("mid rsp_valid c%0d", c), 128'(rsp_valid), 128'(exp_v));
         end
         tick();
      end
      req_en = '0;
      repeat (RL + 3) tick();

      // ---- randomized traffic, requests held until granted ----
      gl = '0;
      for (int n = 0; n < 500; n++) begin
         arstz_aq = ($urandom_range(0, 99) >= 2);
         for (int p = 0; p < P; p++) begin
            if (!req_en[p] || gl[p])
               set_port(p, $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 30,
                        {5'(0), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))},
                        $urandom);
         end
         @(negedge clk);
         gl = req_ready & req_en;
         tick();
      end
      arstz_aq = 1'b1;
      req_en = '0;
      repeat (RL + 4) tick();
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cnnip_mem_arbiter.md
# cnnip_mem_arbiter

Shared-memory access block for the convolution IP. It connects NUM_PORTS requesters to one port of a native block memory through a round-robin arbiter. Reads are fully pipelined at the memory's READ_LATENCY, so any port can issue one access per cycle. Each read response is routed back to the requester that issued it. It replaces per-port read-latency FSMs, which blocked on every read, wherever several engines (feature, weight and output buffers) share one memory port.

## Interface
Parameters:
- NUM_PORTS, 4: number of requesters, 2..8.
- ADDR_WIDTH, 12: byte address width. The memory is word-addressed with addr[ADDR_WIDTH-1:2].
- DATA_WIDTH, 32: data word width.
- READ_LATENCY, 2: memory clock-to-dout latency in cycles, 1..8.

Ports (P = NUM_PORTS):
- clk  in  1  single clock for the block.
- arstz_aq  in  1  reset, synchronous, active-low.
- req_en  in  P  per-port access request.
- req_we  in  P  per-port write enable (1 = write, 0 = read).
- req_addr  in  P*ADDR_WIDTH  per-port byte address. Port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_din  in  P*DATA_WIDTH  per-port write data.
- req_ready  out  P  grant, one-hot or zero, combinational.
- rsp_valid  out  P  read-data valid, one-cycle pulse, registered.
- rsp_dout  out  P*DATA_WIDTH  read data per port.
- busy  out  1  one or more reads are in flight.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH-2  memory word address.
- mem_din  out  DATA_WIDTH  memory write data.
- mem_dout  in  DATA_WIDTH  memory read data, valid READ_LATENCY cycles after the enabled read.

## Operation
- **Arbitration.** Among ports with req_en=1, grant the first one at or after rr_ptr, scanning upward modulo P. Assert req_ready[g] for that port only.
- **Pointer.** rr_ptr resets to 0. After a grant to port g, rr_ptr becomes (g+1) mod P. With no grant, rr_ptr holds.
- **Acceptance.** A request is accepted when req_en[g] & req_ready[g]. In the same cycle: mem_en=1, mem_we=req_we[g], mem_addr=req_addr[g][ADDR_WIDTH-1:2], mem_din=req_din[g].
- **Idle memory outputs.** With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
- **Held requests.** A port not granted holds its request. The block has no request buffering.
- **Tag pipeline.** READ_LATENCY stages, each holding {vld, id[$clog2(P)-1:0]}. Stage 0 loads {accepted & ~we, g}. Each stage shifts every cycle; there is no stall.
- **Read response.** Output register: rsp_valid[id] <= last-stage vld. rsp_dout slice id <= mem_dout when vld, otherwise 0. Non-addressed slices are 0.
- **Writes.** A write completes in its accept cycle and produces no response.
- **busy.** OR of all stage vld bits and the output register valid.
- **Collisions.** Read/write collision behaviour on the same word is defined by the attached memory. The block does no forwarding.
- **Address bits.** Low two address bits are ignored.

## Timing
- **Reset.** While arstz_aq=0 at a clk edge:
  - all tag stages, rsp_valid, rsp_dout, busy and rr_ptr are cleared to 0;
  - req_ready and all mem_* outputs are forced to 0;
  - no access is accepted.
- **Mid-flight reset.** Reset during in-flight reads drops them. No rsp_valid appears after release for reads accepted before reset.
- **Read latency.** Read accepted at edge T: rsp_valid pulses high during cycle T+READ_LATENCY+1, i.e. one cycle after mem_dout is sampled. Fixed, independent of P and load.
- **Throughput.** One accepted access per cycle. Back-to-back reads from one port give consecutive rsp_valid pulses in issue order.
- **Fairness.** With all P ports requesting continuously, each port is granted exactly once every P cycles.
- **No-request cycles.** req_ready is 0 and memory outputs are idle; in-flight responses still drain.
- **Mixed traffic.** A write accepted between reads does not disturb response order or timing of the reads.
- **Minimum latency.** With READ_LATENCY=1 the tag pipeline is one stage, so response cycle = T+2.

## Test plan
- **Single read.** P=4, READ_LATENCY=2, memory preloaded word 5 = 0xA5A5_0005; port 2 reads addr 0x14 at T. Expect:
  - mem_en=1 and mem_addr=5 at T;
  - rsp_valid=4'b0100 with slice 2 = 0xA5A5_0005 only at T+3;
  - busy high T+1..T+3.
- **Round-robin.** All 4 ports hold read requests for 8 cycles. Expect:
  - grant order 0,1,2,3,0,1,2,3;
  - rsp_valid order identical, shifted by 3 cycles.
- **Streaming.** Port 1 issues 16 back-to-back reads of words 0..15 while the others are idle. Expect:
  - 16 consecutive rsp_valid[1] pulses;
  - data in address order;
  - no gaps.
- **Write then read.** Port 0 writes 0xDEAD_BEEF to addr 0x40. Next cycle port 3 reads 0x40, then reads it again 3 cycles later. Expect:
  - the write produces no rsp_valid;
  - the second read returns 0xDEAD_BEEF to port 3.
- **Reset mid-flight.** Issue 3 reads, then assert arstz_aq low for 1 cycle after the first accept. Expect:
  - no rsp_valid for those reads;
  - busy=0 and rr_ptr=0 after release;
  - the next request from port 1 is granted immediately.
- **READ_LATENCY=1 and =4 builds.** Rerun the single-read and streaming scenarios. Expect response at T+2 and T+5 respectively.
